instruction_fetcher: RTL and testbench

Per-core instruction fetch stage sitting directly upstream of the decoder. On a fetch request it reads one 16-bit instruction at the current PC from program memory over a valid/ready read channel. It holds the word stable on `instruction` with `instr_valid` until the decode side acknowledges it. It supports branch flush, including safe draining of an in-flight memory read, and keeps a free-running count of delivered instructions.

---
 rtl/instruction_fetcher_if.sv | 31 +++
 rtl/instruction_fetcher.sv | 95 +++++++++
 tb/tb_instruction_fetcher.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/instruction_fetcher_if.sv
// Fetch-stage bus: program memory read channel, decode handoff and control.
// Signal names follow the block's external interface.
interface instruction_fetcher_if #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
);
    logic                             fetch_req;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] pc;
    logic                             flush;
    logic                             mem_read_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address;
    logic                             mem_read_ready;
    logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instruction;
    logic                             instr_valid;
    logic                             instr_ack;
    logic                             busy;
    logic [15:0]                      fetch_count;

    modport master (
        input  fetch_req, pc, flush, mem_read_ready, mem_read_data, instr_ack,
        output mem_read_valid, mem_read_address, instruction, instr_valid,
        output busy, fetch_count
    );

    modport slave (
        output fetch_req, pc, flush, mem_read_ready, mem_read_data, instr_ack,
        input  mem_read_valid, mem_read_address, instruction, instr_valid,
        input  busy, fetch_count
    );
endinterface

// File: rtl/instruction_fetcher.sv
// Instruction fetch stage: one 16-bit read per request, held until decode
// acknowledges it, with flush that drains an in-flight memory read.
module instruction_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    instruction_fetcher_if.master bus
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] REQ   = 2'b01;
    localparam logic [1:0] HOLD  = 2'b10;
    localparam logic [1:0] DRAIN = 2'b11;

    logic [1:0]                       r_state;
    logic                             r_mem_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] r_mem_addr;
    logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr;
    logic                             r_instr_valid;
    logic                             r_busy;
    logic [15:0]                      r_fetch_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_mem_valid   <= 1'b0;
            r_mem_addr    <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_fetch_count <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.fetch_req) begin
                        r_mem_addr  <= bus.pc;
                        r_mem_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_read_ready) begin
                        r_mem_valid <= 1'b0;
                        if (bus.flush) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_instr       <= bus.mem_read_data;
                            r_instr_valid <= 1'b1;
                            r_fetch_count <= r_fetch_count + 16'h0001;
                            r_state       <= HOLD;
                        end
                    end else if (bus.flush) begin
                        // Request can't be retracted; wait out the read.
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.mem_read_ready) begin
                        r_mem_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                HOLD: begin
                    if (bus.flush) begin
                        r_instr_valid <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else if (bus.instr_ack) begin
                        r_instr_valid <= 1'b0;
                        if (bus.fetch_req) begin
                            r_mem_addr  <= bus.pc;
                            r_mem_valid <= 1'b1;
                            r_state     <= REQ;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_read_valid   = r_mem_valid;
    assign bus.mem_read_address = r_mem_addr;
    assign bus.instruction      = r_instr;
    assign bus.instr_valid      = r_instr_valid;
    assign bus.busy             = r_busy;
    assign bus.fetch_count      = r_fetch_count;
endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed vector bench for instruction_fetcher.
// Vectors apply inputs before an edge and check outputs just after it.
module tb_instruction_fetcher;
    logic clk;
    logic reset;

    instruction_fetcher_if #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16)) bus ();

    instruction_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        freq;
        logic [7:0]  pc;
        logic        flush;
        logic        rdy;
        logic [15:0] data;
        logic        ack;
        logic        e_mv;
        logic [7:0]  e_addr;
        logic [15:0] e_instr;
        logic        e_iv;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    int tests;
    int fails;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic mv, input logic [7:0] addr,
                           input logic [15:0] instr, input logic iv, input logic bsy,
                           input logic [15:0] cnt);
        chk({tag, ".mem_read_valid"}, {15'd0, bus.mem_read_valid}, {15'd0, mv});
        chk({tag, ".mem_read_address"}, {8'd0, bus.mem_read_address}, {8'd0, addr});
        chk({tag, ".instruction"}, bus.instruction, instr);
        chk({tag, ".instr_valid"}, {15'd0, bus.instr_valid}, {15'd0, iv});
        chk({tag, ".busy"}, {15'd0, bus.busy}, {15'd0, bsy});
        chk({tag, ".fetch_count"}, bus.fetch_count, cnt);
    endtask

    task automatic drive(input logic freq, input logic [7:0] pc, input logic flush,
                         input logic rdy, input logic [15:0] data, input logic ack);
        bus.fetch_req      = freq;
        bus.pc             = pc;
        bus.flush          = flush;
        bus.mem_read_ready = rdy;
        bus.mem_read_data  = data;
        bus.instr_ack      = ack;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    vec_t v [$];

    function automatic vec_t mk(
        input logic freq, input logic [7:0] pc, input logic flush, input logic rdy,
        input logic [15:0] data, input logic ack, input logic mv, input logic [7:0] addr,
        input logic [15:0] instr, input logic iv, input logic bsy, input logic [15:0] cnt);
        vec_t r;
        r.freq = freq; r.pc = pc; r.flush = flush; r.rdy = rdy;
        r.data = data; r.ack = ack; r.e_mv = mv; r.e_addr = addr;
        r.e_instr = instr; r.e_iv = iv; r.e_busy = bsy; r.e_cnt = cnt;
        return r;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        //         freq pc     fl rdy data      ack  mv addr   instr     iv bsy cnt
        // basic fetch, memory ready on the third wait cycle
        v.push_back(mk(1, 8'h05, 0, 0, 16'h0000, 0, 1, 8'h05, 16'h0000, 0, 1, 16'd0));
        v.push_back(mk(0, 8'h00, 0, 0, 16'h0000, 0, 1, 8'h05, 16'h0000, 0, 1, 16'd0));
        v.push_back(mk(0, 8'h00, 0, 0, 16'h0000, 0, 1, 8'h05, 16'h0000, 0, 1, 16'd0));
        v.push_back(mk(0, 8'h00, 0, 1, 16'h3123, 0, 0, 8'h05, 16'h3123, 1, 1, 16'd1));
        v.push_back(mk(1, 8'h77, 0, 0, 16'h0000, 0, 0, 8'h05, 16'h3123, 1, 1, 16'd1));
        // back-to-back with zero-wait memory
        v.push_back(mk(1, 8'h06, 0, 0, 16'h0000, 1, 1, 8'h06, 16'h3123, 0, 1, 16'd1));
        v.push_back(mk(0, 8'h00, 0, 1, 16'h9A07, 0, 0, 8'h06, 16'h9A07, 1, 1, 16'd2));
        v.push_back(mk(0, 8'h00, 0, 0, 16'h0000, 1, 0, 8'h06, 16'h9A07, 0, 0, 16'd2));
        // flush in IDLE, then flush during REQ -> DRAIN
        v.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 0, 0, 8'h06, 16'h9A07, 0, 0, 16'd2));
        v.push_back(mk(1, 8'h10, 0, 0, 16'h0000, 0, 1, 8'h10, 16'h9A07, 0, 1, 16'd2));
        v.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 0, 1, 8'h10, 16'h9A07, 0, 1, 16'd2));
        v.push_back(mk(1, 8'h11, 1, 0, 16'h0000, 1, 1, 8'h10, 16'h9A07, 0, 1, 16'd2));
        v.push_back(mk(0, 8'h00, 0, 0, 16'h0000, 0, 1, 8'h10, 16'h9A07, 0, 1, 16'd2));
        v.push_back(mk(0, 8'h00, 0, 0, 16'h0000, 0, 1, 8'h10, 16'h9A07, 0, 1, 16'd2));
        v.push_back(mk(0, 8'h00, 0, 1, 16'hFFFF, 0, 0, 8'h10, 16'h9A07, 0, 0, 16'd2));
        // flush + ack + fetch_req in HOLD
        v.push_back(mk(1, 8'h20, 0, 0, 16'h0000, 0, 1, 8'h20, 16'h9A07, 0, 1, 16'd2));
        v.push_back(mk(0, 8'h00, 0, 1, 16'h1111, 0, 0, 8'h20, 16'h1111, 1, 1, 16'd3));
        v.push_back(mk(1, 8'h30, 1, 0, 16'h0000, 1, 0, 8'h20, 16'h1111, 0, 0, 16'd3));
        v.push_back(mk(0, 8'h00, 0, 1, 16'hAAAA, 1, 0, 8'h20, 16'h1111, 0, 0, 16'd3));
        // ready and flush together in REQ
        v.push_back(mk(1, 8'h40, 0, 0, 16'h0000, 0, 1, 8'h40, 16'h1111, 0, 1, 16'd3));
        v.push_back(mk(0, 8'h00, 1, 1, 16'h2222, 0, 0, 8'h40, 16'h1111, 0, 0, 16'd3));
        // fetch_req ignored while in REQ and in HOLD without ack
        v.push_back(mk(1, 8'h41, 0, 0, 16'h0000, 0, 1, 8'h41, 16'h1111, 0, 1, 16'd3));
        v.push_back(mk(1, 8'h42, 0, 0, 16'h0000, 0, 1, 8'h41, 16'h1111, 0, 1, 16'd3));
        v.push_back(mk(1, 8'h43, 0, 1, 16'h5555, 0, 0, 8'h41, 16'h5555, 1, 1, 16'd4));
        v.push_back(mk(1, 8'h44, 0, 0, 16'h0000, 0, 0, 8'h41, 16'h5555, 1, 1, 16'd4));

        drive(0, 8'h00, 0, 0, 16'h0000, 0);
        reset = 1'b0;
        step();
        step();
        chk_all("reset", 0, 8'h00, 16'h0000, 0, 0, 16'd0);
        reset = 1'b1;

        for (int i = 0; i < v.size(); i++) begin
            drive(v[i].freq, v[i].pc, v[i].flush, v[i].rdy, v[i].data, v[i].ack);
            step();
            chk_all($sformatf("vec%0d", i), v[i].e_mv, v[i].e_addr, v[i].e_instr,
                    v[i].e_iv, v[i].e_busy, v[i].e_cnt);
        end

        // reset while a read is outstanding, then a late ready in IDLE
        drive(1, 8'h50, 0, 0, 16'h0000, 1);
        step();
        chk_all("b2b_req", 1, 8'h50, 16'h5555, 0, 1, 16'd4);
        drive(0, 8'h00, 0, 0, 16'h0000, 0);
        reset = 1'b0;
        step();
        chk_all("rst_mid_req", 0, 8'h00, 16'h0000, 0, 0, 16'd0);
        reset = 1'b1;
        drive(0, 8'h00, 0, 1, 16'hBEEF, 0);
        step();
        chk_all("late_ready", 0, 8'h00, 16'h0000, 0, 0, 16'd0);

        // counter wrap: preload the count instead of 65535 real fetches
        drive(0, 8'h00, 0, 0, 16'h0000, 0);
        @(negedge clk);
        dut.r_fetch_count = 16'hFFFF;
        #1;
        chk("preload", bus.fetch_count, 16'hFFFF);
        drive(1, 8'h60, 0, 0, 16'h0000, 0);
        step();
        drive(0, 8'h00, 0, 1, 16'hC0DE, 0);
        step();
        chk_all("wrap", 0, 8'h60, 16'hC0DE, 1, 1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
